// File: rtl/fpu_dot_accum_if.sv
// Handshake bundle between the dot-product accumulator, its upstream product stream,
// the shared floating-point adder and the downstream consumer.
interface fpu_dot_accum_if;
    logic [31:0] in_data;
    logic        in_stb;
    logic        in_ack;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_stb;
    logic        add_ack;
    logic [31:0] add_z;
    logic        add_z_stb;
    logic        add_z_ack;
    logic [31:0] out_z;
    logic        out_stb;
    logic        out_ack;
    logic        busy;

    // Environment side: product source, adder and result sink.
    modport master (
        output in_data, in_stb,
        input  in_ack,
        input  add_a, add_b, add_stb,
        output add_ack, add_z, add_z_stb,
        input  add_z_ack,
        input  out_z, out_stb,
        output out_ack,
        input  busy
    );

    modport slave (
        input  in_data, in_stb,
        output in_ack,
        output add_a, add_b, add_stb,
        input  add_ack, add_z, add_z_stb,
        output add_z_ack,
        output out_z, out_stb,
        input  out_ack,
        output busy
    );
endinterface

// File: rtl/fpu_dot_accum.sv
// Single-precision dot-product accumulator: issues one acc+term transaction per product
// to an external FP adder, captures the sum, and emits the total after LENGTH terms.
module fpu_dot_accum #(
    parameter int LENGTH = 4
) (
    input logic            clk,
    input logic            rst,
    fpu_dot_accum_if.slave bus
);

    if (LENGTH < 1 || LENGTH > 255) begin : g_bad_length
        $error("fpu_dot_accum: LENGTH must be within 1..255");
    end

    localparam logic [7:0] LAST = 8'(LENGTH - 1);

    typedef enum logic [1:0] {
        GET_TERM,
        SEND_ADD,
        WAIT_SUM,
        PUT_Z
    } state_t;

    state_t      state, state_d;
    logic [31:0] acc, acc_d;
    logic [31:0] term, term_d;
    logic [31:0] out_z, out_z_d;
    logic [7:0]  count, count_d;
    logic        in_ack, in_ack_d;
    logic        add_stb, add_stb_d;
    logic        add_z_ack, add_z_ack_d;
    logic        out_stb, out_stb_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= GET_TERM;
            acc       <= 32'h0000_0000;
            term      <= 32'h0000_0000;
            out_z     <= 32'h0000_0000;
            count     <= 8'd0;
            in_ack    <= 1'b0;
            add_stb   <= 1'b0;
            add_z_ack <= 1'b0;
            out_stb   <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            term      <= term_d;
            out_z     <= out_z_d;
            count     <= count_d;
            in_ack    <= in_ack_d;
            add_stb   <= add_stb_d;
            add_z_ack <= add_z_ack_d;
            out_stb   <= out_stb_d;
        end
    end

    // Strobes toward the adder only rise once its own ready/valid is already seen,
    // so the adder never captures the same operands or result twice.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        term_d      = term;
        out_z_d     = out_z;
        count_d     = count;
        in_ack_d    = 1'b0;
        add_stb_d   = add_stb;
        add_z_ack_d = add_z_ack;
        out_stb_d   = out_stb;

        case (state)
            GET_TERM: begin
                if (bus.in_stb && in_ack) begin
                    term_d  = bus.in_data;
                    state_d = SEND_ADD;
                end else begin
                    in_ack_d = 1'b1;
                end
            end
            SEND_ADD: begin
                if (add_stb && bus.add_ack) begin
                    add_stb_d = 1'b0;
                    state_d   = WAIT_SUM;
                end else if (bus.add_ack) begin
                    add_stb_d = 1'b1;
                end
            end
            WAIT_SUM: begin
                if (bus.add_z_stb && add_z_ack) begin
                    acc_d       = bus.add_z;
                    add_z_ack_d = 1'b0;
                    if (count == LAST) begin
                        out_z_d   = bus.add_z;
                        out_stb_d = 1'b1;
                        state_d   = PUT_Z;
                    end else begin
                        count_d = count + 8'd1;
                        state_d = GET_TERM;
                    end
                end else if (bus.add_z_stb) begin
                    add_z_ack_d = 1'b1;
                end
            end
            PUT_Z: begin
                if (out_stb && bus.out_ack) begin
                    out_stb_d = 1'b0;
                    acc_d     = 32'h0000_0000;
                    count_d   = 8'd0;
                    state_d   = GET_TERM;
                end
            end
            default: begin
                state_d = GET_TERM;
            end
        endcase
    end

    assign bus.in_ack    = in_ack;
    assign bus.add_a     = acc;
    assign bus.add_b     = term;
    assign bus.add_stb   = add_stb;
    assign bus.add_z_ack = add_z_ack;
    assign bus.out_z     = out_z;
    assign bus.out_stb   = out_stb;
    assign bus.busy      = (state != GET_TERM);

endmodule

// File: tb/tb_fpu_dot_accum.sv
// Directed bench for fpu_dot_accum: three instances (LENGTH 4, 2, 1), each with a
// table-driven adder model, plus an adder-handshake monitor.
module tb_fpu_dot_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] in_data   [3];
    logic        in_stb    [3];
    logic        out_ack   [3];
    logic        in_ack_w  [3];
    logic        add_stb_w [3];
    logic        add_zack_w[3];
    logic        out_stb_w [3];
    logic        busy_w    [3];
    logic [31:0] out_z_w   [3];
    logic [31:0] add_a_w   [3];
    logic [31:0] add_b_w   [3];

    int tests_run = 0;
    int tests_failed = 0;

    // Hand-computed single-precision sums for every operand pair the stimulus produces.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h00000000_3F800000: return 32'h3F800000;
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_40400000: return 32'h40C00000;
            64'h40C00000_40800000: return 32'h41200000;
            64'h00000000_3FC00000: return 32'h3FC00000;
            64'h3FC00000_BFC00000: return 32'h00000000;
            64'h00000000_40A00000: return 32'h40A00000;
            64'h40A00000_40A00000: return 32'h41200000;
            64'h00000000_40000000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'h00000000_80000000: return 32'h00000000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_3F800000: return 32'h40400000;
            64'h40400000_3F800000: return 32'h40800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LEN = (g == 0) ? 4 : (g == 1) ? 2 : 1;

        fpu_dot_accum_if bus ();

        fpu_dot_accum #(.LENGTH(LEN)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign bus.in_data   = in_data[g];
        assign bus.in_stb    = in_stb[g];
        assign bus.out_ack   = out_ack[g];
        assign in_ack_w[g]   = bus.in_ack;
        assign add_stb_w[g]  = bus.add_stb;
        assign add_zack_w[g] = bus.add_z_ack;
        assign out_stb_w[g]  = bus.out_stb;
        assign busy_w[g]     = bus.busy;
        assign out_z_w[g]    = bus.out_z;
        assign add_a_w[g]    = bus.add_a;
        assign add_b_w[g]    = bus.add_b;

        logic adder_busy;
        int   wait_cnt;

        // Adder: ready while idle, result valid two cycles after capture.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                bus.add_ack   <= 1'b0;
                bus.add_z_stb <= 1'b0;
                bus.add_z     <= 32'h0;
                adder_busy    <= 1'b0;
                wait_cnt      <= 0;
            end else if (!adder_busy) begin
                if (bus.add_stb && bus.add_ack) begin
                    bus.add_ack <= 1'b0;
                    bus.add_z   <= fp_add(bus.add_a, bus.add_b);
                    adder_busy  <= 1'b1;
                    wait_cnt    <= 2;
                end else begin
                    bus.add_ack <= 1'b1;
                end
            end else if (wait_cnt != 0) begin
                wait_cnt <= wait_cnt - 1;
                if (wait_cnt == 1) bus.add_z_stb <= 1'b1;
            end else if (bus.add_z_stb && bus.add_z_ack) begin
                bus.add_z_stb <= 1'b0;
                adder_busy    <= 1'b0;
            end
        end

        int   stb_pulses = 0;
        int   zack_pulses = 0;
        int   wide_stb = 0;
        int   wide_zack = 0;
        int   early_stb = 0;
        logic prev_stb = 1'b0;
        logic prev_ack = 1'b0;
        logic prev_zack = 1'b0;

        always @(posedge clk) begin
            prev_stb  <= bus.add_stb;
            prev_ack  <= bus.add_ack;
            prev_zack <= bus.add_z_ack;
            if (bus.add_stb && !prev_stb)    stb_pulses  <= stb_pulses + 1;
            if (bus.add_stb && prev_stb)     wide_stb    <= wide_stb + 1;
            if (bus.add_stb && !prev_ack)    early_stb   <= early_stb + 1;
            if (bus.add_z_ack && !prev_zack) zack_pulses <= zack_pulses + 1;
            if (bus.add_z_ack && prev_zack)  wide_zack   <= wide_zack + 1;
        end
    end

    function automatic logic [31:0] flags(input int k);
        return {27'b0, in_ack_w[k], add_stb_w[k], add_zack_w[k], out_stb_w[k], busy_w[k]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic send_term(input int k, input logic [31:0] data);
        int n = 0;
        in_data[k] = data;
        in_stb[k]  = 1'b1;
        while (!in_ack_w[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output("term_accept", {31'b0, in_ack_w[k]}, 32'd1);
        @(negedge clk);
        in_stb[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input logic [31:0] expected, input int hold);
        int n = 0;
        while (!out_stb_w[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output("out_stb", {31'b0, out_stb_w[k]}, 32'd1);
        check_output("out_z", out_z_w[k], expected);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("hold_flags", {29'b0, out_stb_w[k], in_ack_w[k], busy_w[k]}, 32'b101);
            check_output("hold_out_z", out_z_w[k], expected);
        end
        out_ack[k] = 1'b1;
        @(negedge clk);
        out_ack[k] = 1'b0;
        check_output("after_ack", {29'b0, out_stb_w[k], in_ack_w[k], busy_w[k]}, 32'b000);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base_stb, base_zack, base_wide, base_early;

        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data[k] = 32'h0;
            in_stb[k]  = 1'b0;
            out_ack[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_output("rst_flags", flags(k), 32'h0);
            check_output("rst_out_z", out_z_w[k], 32'h0);
            check_output("rst_add_ab", add_a_w[k] | add_b_w[k], 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_output("in_ack_rise", flags(0), 32'b10000);

        // 1+2+3+4 with first-transaction timing on the first term
        send_term(0, 32'h3F800000);
        check_output("accept_flags", flags(0), 32'b00001);
        @(negedge clk);
        check_output("add_stb_rise", flags(0), 32'b01001);
        check_output("add_a_first", add_a_w[0], 32'h00000000);
        check_output("add_b_first", add_b_w[0], 32'h3F800000);
        send_term(0, 32'h40000000);
        send_term(0, 32'h40400000);
        send_term(0, 32'h40800000);
        wait_out(0, 32'h41200000, 0);
        @(negedge clk);
        check_output("in_ack_return", flags(0), 32'b10000);

        // Cancelling pair, then two back-to-back products, then a -0 leading term
        send_term(1, 32'h3FC00000);
        send_term(1, 32'hBFC00000);
        wait_out(1, 32'h00000000, 0);
        send_term(1, 32'h40A00000);
        send_term(1, 32'h40A00000);
        wait_out(1, 32'h41200000, 0);
        send_term(1, 32'h40000000);
        send_term(1, 32'h40000000);
        wait_out(1, 32'h40800000, 0);
        send_term(1, 32'h80000000);
        send_term(1, 32'h3F800000);
        wait_out(1, 32'h3F800000, 0);

        // One term per dot product
        send_term(2, 32'h40000000);
        wait_out(2, 32'h40000000, 0);
        send_term(2, 32'h3F800000);
        wait_out(2, 32'h3F800000, 0);

        // Downstream stall for 10 cycles
        for (int i = 0; i < 4; i++) send_term(0, 32'h3F800000);
        wait_out(0, 32'h40800000, 10);

        // 20 terms through the adder handshake monitor
        base_stb   = g_inst[0].stb_pulses;
        base_zack  = g_inst[0].zack_pulses;
        base_wide  = g_inst[0].wide_stb + g_inst[0].wide_zack;
        base_early = g_inst[0].early_stb;
        for (int d = 0; d < 5; d++) begin
            for (int i = 0; i < 4; i++) send_term(0, 32'h3F800000);
            wait_out(0, 32'h40800000, 0);
        end
        repeat (2) @(negedge clk);
        check_output("add_stb_pulses", 32'(g_inst[0].stb_pulses - base_stb), 32'd20);
        check_output("add_z_ack_pulses", 32'(g_inst[0].zack_pulses - base_zack), 32'd20);
        check_output("wide_pulses",
                     32'(g_inst[0].wide_stb + g_inst[0].wide_zack - base_wide), 32'd0);
        check_output("early_add_stb", 32'(g_inst[0].early_stb - base_early), 32'd0);

        // Asynchronous reset while the sum is being acknowledged
        send_term(0, 32'h3F800000);
        n = 0;
        while (!add_zack_w[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("zack_before_rst", {31'b0, add_zack_w[0]}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("async_rst_flags", flags(0), 32'h0);
        check_output("async_rst_out_z", out_z_w[0], 32'h0);
        check_output("async_rst_add_ab", add_a_w[0] | add_b_w[0], 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) send_term(0, 32'h3F800000);
        wait_out(0, 32'h40800000, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
